// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code controller.
package kbd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEY_W  = BYTE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_DECODE = 2'd2
  } kbd_state_t;

  // Identity of a physical key: E0 prefix flag plus final scan code
  typedef struct packed {
    logic              ext;
    logic [BYTE_W-1:0] code;
  } key_id_t;

  localparam logic [BYTE_W-1:0] SC_BREAK  = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [BYTE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [KEY_W-1:0]  HELD_NONE = 9'h1FF;

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational scan-code (set 2) to ASCII translation for letters, digits,
// space and enter; everything else, and all extended codes, map to 0x00.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [BYTE_W-1:0] code,
  input  logic              ext,
  input  logic              shift,
  input  logic              caps,
  output logic [BYTE_W-1:0] ascii
);

  logic       w_is_let;
  logic [4:0] w_let;
  logic       w_is_dig;
  logic [3:0] w_dig;
  logic [7:0] w_sym;

  always_comb begin
    w_is_let = 1'b1;
    w_let    = 5'd0;
    case (code)
      8'h1C: w_let = 5'd0;   8'h32: w_let = 5'd1;   8'h21: w_let = 5'd2;
      8'h23: w_let = 5'd3;   8'h24: w_let = 5'd4;   8'h2B: w_let = 5'd5;
      8'h34: w_let = 5'd6;   8'h33: w_let = 5'd7;   8'h43: w_let = 5'd8;
      8'h3B: w_let = 5'd9;   8'h42: w_let = 5'd10;  8'h4B: w_let = 5'd11;
      8'h3A: w_let = 5'd12;  8'h31: w_let = 5'd13;  8'h44: w_let = 5'd14;
      8'h4D: w_let = 5'd15;  8'h15: w_let = 5'd16;  8'h2D: w_let = 5'd17;
      8'h1B: w_let = 5'd18;  8'h2C: w_let = 5'd19;  8'h3C: w_let = 5'd20;
      8'h2A: w_let = 5'd21;  8'h1D: w_let = 5'd22;  8'h22: w_let = 5'd23;
      8'h35: w_let = 5'd24;  8'h1A: w_let = 5'd25;
      default: w_is_let = 1'b0;
    endcase
  end

  always_comb begin
    w_is_dig = 1'b1;
    w_dig    = 4'd0;
    case (code)
      8'h45: w_dig = 4'd0;  8'h16: w_dig = 4'd1;  8'h1E: w_dig = 4'd2;
      8'h26: w_dig = 4'd3;  8'h25: w_dig = 4'd4;  8'h2E: w_dig = 4'd5;
      8'h36: w_dig = 4'd6;  8'h3D: w_dig = 4'd7;  8'h3E: w_dig = 4'd8;
      8'h46: w_dig = 4'd9;
      default: w_is_dig = 1'b0;
    endcase
  end

  // US-layout shifted digit row
  always_comb begin
    w_sym = 8'h00;
    case (w_dig)
      4'd0: w_sym = 8'h29;  4'd1: w_sym = 8'h21;  4'd2: w_sym = 8'h40;
      4'd3: w_sym = 8'h23;  4'd4: w_sym = 8'h24;  4'd5: w_sym = 8'h25;
      4'd6: w_sym = 8'h5E;  4'd7: w_sym = 8'h26;  4'd8: w_sym = 8'h2A;
      4'd9: w_sym = 8'h28;
      default: w_sym = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      if (w_is_let)
        ascii = ((shift ^ caps) ? 8'h41 : 8'h61) + 8'(w_let);
      else if (w_is_dig)
        ascii = shift ? w_sym : 8'h30 + 8'(w_dig);
      else if (code == 8'h29)
        ascii = 8'h20;
      else if (code == 8'h5A)
        ascii = 8'h0D;
    end
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-byte consumer: pops bytes from the receiver FIFO, folds F0/E0
// prefixes into key events, tracks modifiers and counts new key presses.
module kbd_scan_ctrl
  import kbd_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              ready,
  input  logic [BYTE_W-1:0] data,
  input  logic              overflow,
  output logic              nextdata_n,
  output logic              key_valid,
  output logic [BYTE_W-1:0] key_code,
  output logic              key_ext,
  output logic              key_down,
  output logic [BYTE_W-1:0] ascii,
  output logic              shift,
  output logic              ctrl,
  output logic              caps,
  output logic [BYTE_W-1:0] press_cnt,
  output logic              err
);

  kbd_state_t r_state;
  kbd_state_t w_state_nxt;
  logic       w_nextdata_n_nxt;
  logic       w_capture;
  logic       w_decode;

  logic [BYTE_W-1:0] r_byte;
  logic              r_brk;
  logic              r_ext;
  key_id_t           r_held;

  logic              r_nextdata_n;
  logic              r_key_valid;
  logic [BYTE_W-1:0] r_key_code;
  logic              r_key_ext;
  logic              r_key_down;
  logic [BYTE_W-1:0] r_ascii;
  logic              r_shift;
  logic              r_ctrl;
  logic              r_caps;
  logic [BYTE_W-1:0] r_press_cnt;
  logic              r_err;

  logic              w_is_brk;
  logic              w_is_ext;
  logic              w_event;
  logic              w_make;
  logic              w_same;
  logic              w_is_shift;
  key_id_t           w_key;
  logic [BYTE_W-1:0] w_ascii;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_nextdata_n_nxt = 1'b1;
    w_capture        = 1'b0;
    w_decode         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ready) begin
          w_state_nxt      = ST_ACK;
          w_nextdata_n_nxt = 1'b0;
          w_capture        = 1'b1;
        end
      end
      ST_ACK:    w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        w_state_nxt = ST_IDLE;
        w_decode    = 1'b1;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_is_brk   = (r_byte == SC_BREAK);
  assign w_is_ext   = (r_byte == SC_EXT);
  assign w_event    = w_decode && !w_is_brk && !w_is_ext;
  assign w_key      = '{ext: r_ext, code: r_byte};
  assign w_make     = !r_brk;
  assign w_same     = (w_key == r_held);
  assign w_is_shift = !r_ext && ((r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT));

  // Translation uses modifier state as it stood before this event
  kbd_scan2ascii u_scan2ascii (
    .code  (r_byte),
    .ext   (r_ext),
    .shift (r_shift),
    .caps  (r_caps),
    .ascii (w_ascii)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_byte       <= '0;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_held       <= key_id_t'(HELD_NONE);
      r_nextdata_n <= 1'b1;
      r_key_valid  <= 1'b0;
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_key_down   <= 1'b0;
      r_ascii      <= '0;
      r_shift      <= 1'b0;
      r_ctrl       <= 1'b0;
      r_caps       <= 1'b0;
      r_press_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_nextdata_n <= w_nextdata_n_nxt;
      r_key_valid  <= w_event;
      r_err        <= r_err | overflow;
      if (w_capture) r_byte <= data;
      if (w_decode) begin
        if (w_is_brk) begin
          r_brk <= 1'b1;
        end else if (w_is_ext) begin
          r_ext <= 1'b1;
        end else begin
          r_brk      <= 1'b0;
          r_ext      <= 1'b0;
          r_key_code <= r_byte;
          r_key_ext  <= r_ext;
          r_key_down <= w_make;
          r_ascii    <= w_ascii;
          // A make of the already-held key is typematic repeat, not a press
          if (w_make && !w_same) begin
            r_press_cnt <= r_press_cnt + 8'd1;
            r_held      <= w_key;
            if (r_byte == SC_CAPS) r_caps <= ~r_caps;
          end else if (!w_make && w_same) begin
            r_held <= key_id_t'(HELD_NONE);
          end
          if (w_is_shift)         r_shift <= w_make;
          if (r_byte == SC_CTRL)  r_ctrl  <= w_make;
        end
      end
    end
  end

  assign nextdata_n = r_nextdata_n;
  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_down   = r_key_down;
  assign ascii      = r_ascii;
  assign shift      = r_shift;
  assign ctrl       = r_ctrl;
  assign caps       = r_caps;
  assign press_cnt  = r_press_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: emulated receiver FIFO, event-level reference model.
module tb_kbd_scan_ctrl;

  logic       clk, clrn, ready, overflow;
  logic [7:0] data;
  logic       nextdata_n, key_valid, key_ext, key_down, shift, ctrl, caps, err;
  logic [7:0] key_code, ascii, press_cnt;

  kbd_scan_ctrl dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_down(key_down), .ascii(ascii), .shift(shift),
    .ctrl(ctrl), .caps(caps), .press_cnt(press_cnt), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] LET_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       down;
    logic [7:0] asc;
    logic       sh;
    logic       ct;
    logic       cp;
    logic [7:0] cnt;
  } ev_t;

  int n_checks = 0;
  int n_err    = 0;
  int n_pops   = 0;
  int n_kv     = 0;
  int cyc      = 0;
  int last_pop = -100;
  logic prev_nd = 1'b1;
  logic prev_kv = 1'b0;
  logic pop_pend = 1'b0;

  logic [7:0] rx_q [$];
  ev_t        exp_q [$];

  // Reference model state: key events at the level of "pressed / released keys"
  logic       m_brk, m_ext, m_shift, m_ctrl, m_caps;
  logic [8:0] m_held;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input logic e,
                                         input logic sh, input logic cp);
    string sym = ")!@#$%^&*(";
    if (e) return 8'h00;
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    for (int i = 0; i < 26; i++)
      if (c == LET_CODES[i]) return 8'((sh ^ cp) ? 65 + i : 97 + i);
    for (int i = 0; i < 10; i++)
      if (c == DIG_CODES[i]) return sh ? 8'(sym[i]) : 8'(48 + i);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
    m_held = 9'h1FF; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t        ev;
    logic [8:0] key;
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      key     = {m_ext, b};
      ev.code = b;
      ev.ext  = m_ext;
      ev.down = !m_brk;
      ev.asc  = m_ascii(b, m_ext, m_shift, m_caps);
      if (ev.down && key != m_held) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_held = key;
        if (b == 8'h58) m_caps = !m_caps;
      end else if (!ev.down && key == m_held) begin
        m_held = 9'h1FF;
      end
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = ev.down;
      if (b == 8'h14) m_ctrl = ev.down;
      ev.sh  = m_shift;
      ev.ct  = m_ctrl;
      ev.cp  = m_caps;
      ev.cnt = 8'(m_cnt);
      exp_q.push_back(ev);
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
  endtask

  // Receiver FIFO: pops on an edge where ready=1 and nextdata_n=0
  always @(posedge clk) begin
    #1;
    if (pop_pend && clrn && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      n_pops++;
    end
    ready = (rx_q.size() != 0);
    data  = ready ? rx_q[0] : 8'h00;
  end

  // Protocol and event monitor
  always @(negedge clk) begin
    ev_t e;
    if (clrn) begin
      if (!nextdata_n) begin
        chk("nd_single_cycle", 32'(prev_nd), 1);
        chk("nd_gap_ge3", 32'(cyc - last_pop >= 3), 1);
        last_pop = cyc;
      end
      if (key_valid) begin
        n_kv++;
        chk("kv_single_cycle", 32'(prev_kv), 0);
        chk("kv_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ev_code", 32'(key_code), 32'(e.code));
          chk("ev_ext", 32'(key_ext), 32'(e.ext));
          chk("ev_down", 32'(key_down), 32'(e.down));
          chk("ev_ascii", 32'(ascii), 32'(e.asc));
          chk("ev_mods", 32'({shift, ctrl, caps}), 32'({e.sh, e.ct, e.cp}));
          chk("ev_cnt", 32'(press_cnt), 32'(e.cnt));
        end
      end
    end
    pop_pend = clrn && ready && !nextdata_n;
    prev_nd  = nextdata_n;
    prev_kv  = key_valid;
    cyc++;
  end

  task automatic do_reset();
    clrn = 1'b0;
    rx_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    chk("drain_in_time", 32'(budget < 5000), 1);
    chk("all_events_seen", 32'(exp_q.size()), 0);
  endtask

  function automatic logic [31:0] outs();
    return {nextdata_n, key_valid, key_code, key_ext, key_down, ascii,
            shift, ctrl, caps, press_cnt, err};
  endfunction

  initial begin
    int p0, k0, r, seen;
    logic [7:0] b, last_b;
    clk = 0; clrn = 0; ready = 0; data = 0; overflow = 0;
    model_reset();
    do_reset();
    chk("reset_outputs", outs(), 32'h8000_0000);

    // single key press
    p0 = n_pops; k0 = n_kv;
    push(8'h1C);
    drain();
    chk("r033_pops", 32'(n_pops - p0), 1);
    chk("r033_kv", 32'(n_kv - k0), 1);
    chk("r033_code", 32'(key_code), 32'h1C);
    chk("r033_down", 32'(key_down), 1);
    chk("r033_ascii", 32'(ascii), 32'h61);
    chk("r033_cnt", 32'(press_cnt), 1);

    // shifted letter
    do_reset();
    push(8'h12); push(8'h1C);
    drain();
    chk("r034_make_ascii", 32'(ascii), 32'h41);
    push(8'hF0); push(8'h1C);
    drain();
    chk("r034_brk_ascii", 32'(ascii), 32'h41);
    chk("r034_brk_down", 32'(key_down), 0);
    push(8'hF0); push(8'h12);
    drain();
    chk("r034_shift_off", 32'(shift), 0);
    chk("r034_cnt", 32'(press_cnt), 2);

    // typematic repeat
    do_reset();
    k0 = n_kv;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("r035_kv", 32'(n_kv - k0), 4);
    chk("r035_cnt", 32'(press_cnt), 1);

    // extended key, with repeated prefixes on the break
    do_reset();
    push(8'hE0); push(8'h75);
    drain();
    chk("r036_make", 32'({key_ext, key_code, ascii, key_down}), 32'({1'b1, 8'h75, 8'h00, 1'b1}));
    push(8'hE0); push(8'hE0); push(8'hF0); push(8'hF0); push(8'h75);
    drain();
    chk("r036_break", 32'({key_ext, key_code, ascii, key_down}), 32'({1'b1, 8'h75, 8'h00, 1'b0}));

    // caps lock, back-to-back bytes, overflow
    do_reset();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
    drain();
    chk("r037_caps", 32'(caps), 1);
    chk("r037_ascii", 32'(ascii), 32'h41);
    p0 = n_pops;
    for (int i = 0; i < 8; i++) push(LET_CODES[i + 3]);
    drain();
    chk("r037_burst_pops", 32'(n_pops - p0), 8);
    chk("r037_err_before", 32'(err), 0);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (5) @(negedge clk);
    chk("r037_err_sticky", 32'(err), 1);

    // asynchronous reset while the pop is in flight
    do_reset();
    push(8'h12); push(8'h1C);
    drain();
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    push(8'h32);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (!nextdata_n) seen = 1;
    end
    chk("r038_reached_ack", 32'(seen), 1);
    #1 clrn = 1'b0;
    #1 chk("r038_async_reset", outs(), 32'h8000_0000);
    do_reset();
    push(8'h1C);
    drain();
    chk("r038_restart", 32'({press_cnt, ascii}), 32'({8'd1, 8'h61}));

    // press counter wrap
    do_reset();
    for (int i = 0; i < 300; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    chk("cnt_wrap", 32'(press_cnt), 32'(300 % 256));

    // randomized byte stream with idle gaps
    do_reset();
    last_b = 8'h1C;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0:       b = 8'hF0;
        1:       b = 8'hE0;
        2: begin
          case ($urandom_range(0, 3))
            0: b = 8'h12; 1: b = 8'h59; 2: b = 8'h14; default: b = 8'h58;
          endcase
        end
        3, 4:    b = LET_CODES[$urandom_range(0, 25)];
        5:       b = DIG_CODES[$urandom_range(0, 9)];
        6:       b = ($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A;
        7, 8:    b = last_b;
        default: b = 8'($urandom_range(0, 255));
      endcase
      push(b);
      last_b = b;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    chk("rand_cnt", 32'(press_cnt), 32'(m_cnt));
    chk("rand_mods", 32'({shift, ctrl, caps}), 32'({m_shift, m_ctrl, m_caps}));
    chk("rand_nd_idle", 32'(nextdata_n), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
